// File: rtl/dff_response_checker.sv
// Scoreboard for a D latch/flip-flop DUT: captures d_in on c_in rising edges, compares q_in/qn_in after a settle delay.
// Latency: compare SETTLE_CYC cycles after the captured edge; chk_cnt/err_cnt/err_pulse update one cycle after the compare.
// Backpressure: none; inputs are observed every cycle. Optional first-failure log enabled by macro DFF_CHK_FAIL_LOG_EN.
module dff_response_checker #(
  parameter int NUM_CHECKS = 16,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             d_in,
  input  logic             c_in,
  input  logic             q_in,
  input  logic             qn_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_CHK = CNT_W'(NUM_CHECKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               c_prev_q;
  logic               exp_q, exp_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_pulse_q, err_pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic               edge_det;
  logic               clr;
  logic               overlap;
  logic               mismatch;
  logic [CNT_W-1:0]   chk_nxt;
  logic [1:0]         err_inc;
  logic [CNT_W:0]     err_sum;

  assign edge_det = c_in & ~c_prev_q;
  assign chk_nxt  = chk_cnt_q + 1'b1;

  // Next-state, compare and counter logic; errors from an overlap and a mismatch in the same cycle both count
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    chk_cnt_d = chk_cnt_q;
    clr      = 1'b0;
    overlap  = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // An edge coinciding with start is deliberately not captured
        if (start) begin
          state_d = ST_ARMED;
          clr     = 1'b1;
        end
      end
      ST_ARMED: begin
        if (edge_det) begin
          exp_d   = d_in;
          cnt_d   = SET_W'(SETTLE_CYC - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Any edge while waiting (including on the compare cycle) is a protocol error and is dropped
        overlap = edge_det;
        if (cnt_q == '0) begin
          mismatch  = (q_in != exp_q) || (qn_in != ~exp_q);
          chk_cnt_d = chk_nxt;
          state_d   = (chk_nxt == LAST_CHK) ? ST_DONE : ST_ARMED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_inc   = {1'b0, overlap} + {1'b0, mismatch};
    err_sum   = {1'b0, err_cnt_q} + (CNT_W+1)'(err_inc);
    err_cnt_d = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
    if (clr) begin
      chk_cnt_d = '0;
      err_cnt_d = '0;
    end

    err_pulse_d = overlap | mismatch;
    busy_d      = (state_d == ST_ARMED) || (state_d == ST_SETTLE);
    done_d      = (state_d == ST_DONE);
    if (clr) begin
      pass_d = 1'b0;
    end else if ((state_q == ST_SETTLE) && (state_d == ST_DONE)) begin
      pass_d = (err_cnt_d == '0);
    end else begin
      pass_d = pass_q;
    end
  end

  // Single state/output register bank with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      c_prev_q    <= 1'b0;
      exp_q       <= 1'b0;
      cnt_q       <= '0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_prev_q    <= c_in;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      chk_cnt_q   <= chk_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_pulse = err_pulse_q;
  assign chk_cnt   = chk_cnt_q;
  assign err_cnt   = err_cnt_q;

`ifdef DFF_CHK_FAIL_LOG_EN
  logic             ff_seen_q, ff_seen_d;
  logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;

  // Latch the pre-increment check index at the first error of a run; sticky until next start
  always_comb begin
    ff_seen_d        = ff_seen_q;
    first_fail_idx_d = first_fail_idx_q;
    if (clr) begin
      ff_seen_d        = 1'b0;
      first_fail_idx_d = '0;
    end else if ((overlap | mismatch) && !ff_seen_q) begin
      ff_seen_d        = 1'b1;
      first_fail_idx_d = chk_cnt_q;
    end
  end

  // First-failure log registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_seen_q        <= 1'b0;
      first_fail_idx_q <= '0;
    end else begin
      ff_seen_q        <= ff_seen_d;
      first_fail_idx_q <= first_fail_idx_d;
    end
  end

  assign first_fail_idx = first_fail_idx_q;
`else
  assign first_fail_idx = '0;
`endif

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: two instances (default, and CNT_W=2/NUM_CHECKS=3) share one stimulus stream.
// A timestamp-based reference model predicts every output each cycle; directed checks cover the named scenarios.
module tb_dff_response_checker;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n, start, d_in, c_in;
  logic q_in, qn_in;

  logic       busy0, done0, pass0, ep0;
  logic [7:0] chk0, err0, ffi0;
  logic       busy1, done1, pass1, ep1;
  logic [1:0] chk1, err1, ffi1;

  // Behavioural stand-in for the device under observation, with fault injection
  logic ff_q = 1'b0;
  logic ff_cprev = 1'b0;
  bit   stuck = 1'b0;
  bit   flip_qn = 1'b0;
  assign q_in  = stuck ? 1'b0 : ff_q;
  assign qn_in = flip_qn ? q_in : ~q_in;

  always @(posedge clk) begin
    if (c_in && !ff_cprev) ff_q <= d_in;
    ff_cprev <= c_in;
  end

  always #5 clk = ~clk;

  dff_response_checker #(.NUM_CHECKS(16), .SETTLE_CYC(S), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_in(d_in), .c_in(c_in), .q_in(q_in), .qn_in(qn_in),
    .busy(busy0), .done(done0), .pass(pass0), .err_pulse(ep0),
    .chk_cnt(chk0), .err_cnt(err0), .first_fail_idx(ffi0));

  dff_response_checker #(.NUM_CHECKS(3), .SETTLE_CYC(S), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .d_in(d_in), .c_in(c_in), .q_in(q_in), .qn_in(qn_in),
    .busy(busy1), .done(done1), .pass(pass1), .err_pulse(ep1),
    .chk_cnt(chk1), .err_cnt(err1), .first_fail_idx(ffi1));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_nchk[2] = '{16, 3};
  int m_max[2]  = '{255, 3};
  int cyc = 0;
  bit m_cprev;
  bit m_busy[2], m_done[2], m_pass[2], m_pulse[2], m_exp[2], m_ffseen[2];
  int m_chk[2], m_err[2], m_ffi[2], m_pend[2];

  task automatic model_reset();
    m_cprev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_pulse[i] = 0; m_exp[i] = 0;
      m_ffseen[i] = 0; m_chk[i] = 0; m_err[i] = 0; m_ffi[i] = 0; m_pend[i] = -1;
    end
  endtask

  // A run is a window of NUM_CHECKS compares; each captured edge schedules its compare at an absolute cycle.
  task automatic model_step(input int i, input bit edge_seen);
    int errs;
    int chk_pre;
    errs = 0;
    chk_pre = m_chk[i];
    if (start && !m_busy[i]) begin
      m_busy[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_chk[i] = 0; m_err[i] = 0;
      m_ffi[i] = 0; m_ffseen[i] = 0; m_pend[i] = -1;
    end else if (m_busy[i]) begin
      if (m_pend[i] >= 0) begin
        if (edge_seen) errs++;
        if (cyc == m_pend[i]) begin
          if (q_in !== m_exp[i] || qn_in !== !m_exp[i]) errs++;
          m_chk[i]++;
          m_pend[i] = -1;
          if (m_chk[i] == m_nchk[i]) begin
            m_busy[i] = 0;
            m_done[i] = 1;
          end
        end
      end else if (edge_seen) begin
        m_pend[i] = cyc + S;
        m_exp[i]  = d_in;
      end
    end
    m_err[i] = (m_err[i] + errs > m_max[i]) ? m_max[i] : m_err[i] + errs;
    m_pulse[i] = (errs > 0);
`ifdef DFF_CHK_FAIL_LOG_EN
    if (errs > 0 && !m_ffseen[i]) begin
      m_ffseen[i] = 1;
      m_ffi[i] = chk_pre;
    end
`endif
    if (m_done[i] && errs == 0 && m_chk[i] == m_nchk[i] && m_pend[i] < 0 && !m_busy[i] && chk_pre != m_chk[i])
      m_pass[i] = (m_err[i] == 0);
    else if (m_done[i] && chk_pre != m_chk[i])
      m_pass[i] = (m_err[i] == 0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit e;
      cyc++;
      e = c_in && !m_cprev;
      model_step(0, e);
      model_step(1, e);
      m_cprev = c_in;
    end
  end

  // ---------------- per-cycle comparison ----------------
  int pulse_cnt = 0;
  int pulse_seen_cyc = -1;

  function automatic logic [31:0] obs0();
    return {4'b0, busy0, done0, pass0, ep0, chk0, err0, ffi0};
  endfunction
  function automatic logic [31:0] obs1();
    return {22'b0, busy1, done1, pass1, ep1, chk1, err1, ffi1};
  endfunction

  always @(posedge clk) begin
    #1;
    check("cyc_main", obs0(), {4'b0, m_busy[0], m_done[0], m_pass[0], m_pulse[0],
                               8'(m_chk[0]), 8'(m_err[0]), 8'(m_ffi[0])});
    check("cyc_sat", obs1(), {22'b0, m_busy[1], m_done[1], m_pass[1], m_pulse[1],
                              2'(m_chk[1]), 2'(m_err[1]), 2'(m_ffi[1])});
    if (ep0) begin
      pulse_cnt++;
      if (pulse_seen_cyc < 0) pulse_seen_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  int edge_cyc;
  int flip_edge;

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse(input logic d);
    @(negedge clk); d_in = d; c_in = 1'b1; edge_cyc = cyc + 1;
    @(negedge clk); c_in = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic run16(input int flip_at);
    for (int i = 0; i < 16; i++) begin
      if (i == flip_at) flip_qn = 1'b1;
      pulse(1'(i % 2));
      if (i == flip_at) flip_edge = edge_cyc;
      flip_qn = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; d_in = 1'b0; c_in = 1'b0;
    #12;
    check("reset_main", obs0(), 32'h0);
    check("reset_sat", obs1(), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Asynchronous reset in the middle of a settle window
    do_start();
    @(negedge clk); d_in = 1'b1; c_in = 1'b1;
    @(negedge clk); c_in = 1'b0;
    @(posedge clk); #3;
    check("pre_rst_busy", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_async_main", obs0(), 32'h0);
    check("rst_async_sat", obs1(), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'(busy0), 32'h0);

    // Good device, alternating data
    do_start();
    run16(-1);
    check("good_done", 32'(done0), 32'h1);
    check("good_pass", 32'(pass0), 32'h1);
    check("good_chk", 32'(chk0), 32'd16);
    check("good_err", 32'(err0), 32'd0);

    // Stuck-at-0 Q: every D=1 check fails
    do_start();
    pulse_cnt = 0;
    stuck = 1'b1;
    run16(-1);
    stuck = 1'b0;
    check("stuck_err", 32'(err0), 32'd8);
    check("stuck_pulses", 32'(pulse_cnt), 32'd8);
    check("stuck_pass", 32'(pass0), 32'h0);
    check("stuck_done", 32'(done0), 32'h1);
`ifdef DFF_CHK_FAIL_LOG_EN
    check("stuck_ffi", 32'(ffi0), 32'd1);
`else
    check("stuck_ffi", 32'(ffi0), 32'd0);
`endif

    // Wrong complement on the third check only
    do_start();
    pulse_cnt = 0; pulse_seen_cyc = -1;
    run16(2);
    check("cmpl_err", 32'(err0), 32'd1);
    check("cmpl_pulses", 32'(pulse_cnt), 32'd1);
    check("cmpl_pulse_time", 32'(pulse_seen_cyc - flip_edge), 32'(S));
`ifdef DFF_CHK_FAIL_LOG_EN
    check("cmpl_ffi", 32'(ffi0), 32'd2);
`endif

    // Overlap: second edge lands on the compare cycle of the first
    do_start();
    @(negedge clk); d_in = 1'b1; c_in = 1'b1;
    @(negedge clk); c_in = 1'b0;
    @(negedge clk); c_in = 1'b1;
    @(negedge clk); c_in = 1'b0;
    repeat (8) @(negedge clk);
    check("ovl_err", 32'(err0), 32'd1);
    check("ovl_chk", 32'(chk0), 32'd1);
    for (int i = 0; i < 15; i++) pulse(1'($urandom_range(0, 1)));
    check("ovl_done_chk", 32'(chk0), 32'd16);
    check("ovl_pass", 32'(pass0), 32'h0);

    // Saturation on the narrow instance: every check fails and every compare overlaps
    do_start();
    stuck = 1'b1; d_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); c_in = ~c_in;
    end
    @(negedge clk); c_in = 1'b0; stuck = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_err", 32'(err1), 32'd3);
    check("sat_chk", 32'(chk1), 32'd3);
    check("sat_done", 32'(done1), 32'h1);
    check("sat_pass", 32'(pass1), 32'h0);
    do_start();
    check("sat_restart", obs1() & 32'h3F0, 32'h200);

    // Randomized traffic, including random starts, faults and resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 499) != 0);
      start   = ($urandom_range(0, 39) == 0);
      c_in    = ($urandom_range(0, 2) == 0);
      d_in    = 1'($urandom_range(0, 1));
      flip_qn = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) stuck = ~stuck;
    end
    @(negedge clk); rst_n = 1'b1; start = 1'b0; c_in = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
